// File: rtl/cfglut5_cfg_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cfglut5_cfg_ctrl_if
// Description : Bundle for the CFGLUT5 reconfiguration controller. It carries
//               the image request handshake, the serial chain pins
//               (ce/cdi/cdo) and the status outputs.
// Signals     : cfg_valid/cfg_ready/cfg_data - image request handshake
//               ce/cdi                       - chain clock enable, serial in
//               cdo                          - serial out of the chain tail
//               old_data                     - previous chain contents
//               busy/done/verify_err         - status
// Modports    : slave  - controller side
//               master - requester plus chain side
// Revision    : 1.0 - initial release
// ============================================================================
interface cfglut5_cfg_ctrl_if #(
  parameter int NUM_LUT = 1
);
  localparam int c_len = 32 * NUM_LUT;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [c_len-1:0] cfg_data;
  logic             ce;
  logic             cdi;
  logic             cdo;
  logic [c_len-1:0] old_data;
  logic             busy;
  logic             done;
  logic             verify_err;

  modport slave (
    input  cfg_valid, cfg_data, cdo,
    output cfg_ready, ce, cdi, old_data, busy, done, verify_err
  );

  modport master (
    output cfg_valid, cfg_data, cdo,
    input  cfg_ready, ce, cdi, old_data, busy, done, verify_err
  );
endinterface
`default_nettype wire

// File: rtl/cfglut5_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cfglut5_cfg_ctrl
// Description : Serially loads a packed INIT image (MSB first) into a chain of
//               NUM_LUT cascaded CFGLUT5 primitives, capturing the previous
//               chain contents from the tail while shifting. With VERIFY=1 a
//               second pass rewrites the same image and compares readback.
// Ports       : clk   - clock, shared with the CFGLUT5 CLK pins
//               rst_n - asynchronous active-low reset
//               bus   - cfglut5_cfg_ctrl_if.slave (handshake, chain, status)
// Revision    : 1.0 - initial release
// ============================================================================
module cfglut5_cfg_ctrl #(
  parameter int NUM_LUT = 1,
  parameter bit VERIFY  = 1'b0
) (
  input wire logic          clk,
  input wire logic          rst_n,
  cfglut5_cfg_ctrl_if.slave bus
);
  localparam int              c_len  = 32 * NUM_LUT;
  localparam int              c_cw   = $clog2(c_len) + 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(c_len - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [c_len-1:0] r_sh;
  logic [c_len-1:0] w_sh_nxt;
  logic [c_len-1:0] r_img;
  logic [c_len-1:0] w_img_nxt;
  logic [c_len-1:0] r_old;
  logic [c_len-1:0] w_old_nxt;
  logic [c_cw-1:0]  r_cnt;
  logic [c_cw-1:0]  w_cnt_nxt;
  logic             r_verr;
  logic             w_verr_nxt;
  logic             r_ce;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;
  logic             w_last;

  assign w_last = (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_img_nxt   = r_img;
    w_old_nxt   = r_old;
    w_cnt_nxt   = r_cnt;
    w_verr_nxt  = r_verr;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.cfg_valid && r_ready) begin
          w_sh_nxt    = bus.cfg_data;
          w_img_nxt   = bus.cfg_data;
          w_verr_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_sh_nxt  = r_sh << 1;
        w_old_nxt = {r_old[c_len-2:0], bus.cdo};
        w_cnt_nxt = r_cnt + c_cw'(1);
        if (w_last) begin
          w_cnt_nxt = '0;
          if (VERIFY) begin
            w_sh_nxt    = r_img;
            w_state_nxt = ST_VERIFY;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_VERIFY: begin
        // The tail bit emerging now is the one shifted in L edges earlier,
        // i.e. the same image bit currently being presented on cdi.
        if (bus.cdo != r_sh[c_len-1]) begin
          w_verr_nxt = 1'b1;
        end
        w_sh_nxt  = r_sh << 1;
        w_cnt_nxt = r_cnt + c_cw'(1);
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with
  // the state they describe and have no combinational path from inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh    <= '0;
      r_img   <= '0;
      r_old   <= '0;
      r_cnt   <= '0;
      r_verr  <= 1'b0;
      r_ce    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_sh    <= w_sh_nxt;
      r_img   <= w_img_nxt;
      r_old   <= w_old_nxt;
      r_cnt   <= w_cnt_nxt;
      r_verr  <= w_verr_nxt;
      r_ce    <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_VERIFY);
      r_busy  <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_VERIFY);
      r_done  <= (w_state_nxt == ST_DONE);
      r_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  // The shift register is fully drained after every pass, so its MSB is 0
  // whenever no shift is in progress.
  assign bus.cdi        = r_sh[c_len-1];
  assign bus.ce         = r_ce;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.cfg_ready  = r_ready;
  assign bus.verify_err = r_verr;
  assign bus.old_data   = r_old;
endmodule
`default_nettype wire

// File: doc/cfglut5_cfg_ctrl.md
# cfglut5_cfg_ctrl

Runtime reconfiguration controller for a chain of CFGLUT5 primitives, the shift-register-loadable sibling of the fixed-INIT LUT5 models in this library. It accepts a packed INIT image over a valid/ready handshake and serially shifts it into `NUM_LUT` cascaded LUTs (CDI→CDO chain) by driving `CE`/`CDI`. While shifting, it captures the previous contents from the chain tail, and it can optionally re-shift the image to verify it.

## Interface
- `NUM_LUT`, default 1: number of CFGLUT5 in the chain (1..8). Total image length `L = 32*NUM_LUT`.
- `VERIFY`, default 0: 1 enables a second shift pass that compares readback against the image.
- `CLK` input 1: clock, rising edge; shared with the CFGLUT5 `CLK` pins.
- `RST_N` input 1: reset, asynchronous, active-low.
- `CFG_VALID` input 1: image request.
- `CFG_READY` output 1: controller can accept an image.
- `CFG_DATA` input L: image; `CFG_DATA[32k+31:32k]` is the INIT of LUT k (LUT 0 is fed by `CDI`).
- `CE` output 1: clock enable to every CFGLUT5 in the chain.
- `CDI` output 1: serial data to LUT 0.
- `CDO` input 1: serial output of LUT `NUM_LUT-1`.
- `OLD_DATA` output L: previous chain contents, same packing as `CFG_DATA`.
- `BUSY` output 1: shift in progress.
- `DONE` output 1: one-cycle pulse at the end of the operation.
- `VERIFY_ERR` output 1: sticky readback mismatch flag.

## Operation
- CFGLUT5 model: on a `CLK` edge with `CE=1`, `INIT <= {INIT[30:0], CDI}`. `CDO` is `INIT[31]` combinationally.
- States:
  - IDLE:
    - `CFG_READY=1`.
    - On `CFG_VALID & CFG_READY`: latch `CFG_DATA` into shift register `sh` and hold copy `img`, clear `VERIFY_ERR`, clear counter, go to LOAD.
  - LOAD:
    - `CE=1`, `CDI=sh[L-1]`.
    - Each edge: `sh <= sh<<1`, shift `CDO` into `OLD_DATA` LSB (`OLD_DATA <= {OLD_DATA[L-2:0], CDO}`), increment counter.
    - After L edges: go to VERIFY if `VERIFY=1` (reload `sh <= img`), else go to DONE.
  - VERIFY:
    - `CE=1`, `CDI=sh[L-1]`.
    - Each edge: compare `CDO` against `sh[L-1]`; any mismatch sets `VERIFY_ERR`. The chain is rewritten with identical data.
    - After L edges: go to DONE.
  - DONE: `DONE=1` for one cycle, then go to IDLE.
- Shift order: `CFG_DATA` MSB first. Bit L-1 enters first and ends at LUT `NUM_LUT-1` bit 31; bit 0 enters last and ends at LUT 0 bit 0.
- `OLD_DATA` uses the same packing. It updates only during LOAD and holds until the next LOAD.
- Counter width `$clog2(L)+1`. Terminal count is `L-1`. No wrap is visible outside.
- `CE`, `CDI`, `BUSY`, `DONE`, `CFG_READY` and `VERIFY_ERR` are driven from registers; no combinational path from inputs.
- `CFG_VALID` outside IDLE is ignored; it is not queued. `CFG_DATA` is sampled only at accept.

## Timing
- Reset values: state IDLE, `CE=0`, `CDI=0`, `BUSY=0`, `DONE=0`, `CFG_READY=1`, `VERIFY_ERR=0`, `OLD_DATA=0`, counter 0.
- Accept at edge 0 → `CE=1`, `BUSY=1`, `CFG_READY=0` from cycle 1 through cycle L (`VERIFY=0`) or through cycle 2L (`VERIFY=1`).
- `DONE` is high in cycle L+1 (or 2L+1), with `CE=0` and `BUSY=0`. `CFG_READY=1` from cycle L+2 (or 2L+2).
- Minimum request-to-request spacing: L+2 cycles, or 2L+2 with verify.
- `VERIFY_ERR` is valid from the `DONE` cycle and holds until the next accept.
- Reset asserted mid-operation: `CE` drops asynchronously, and the chain keeps a partially shifted image. Software must reload after reset; the controller does not restore the image.
- Back-to-back: `CFG_VALID` held high continuously gives one accept per L+2 (or 2L+2) cycles.

## Test plan
- `NUM_LUT=1`, `VERIFY=0`, image 32'hCAFE_F00D after reset:
  - `CE` high exactly 32 cycles and `DONE` at cycle 33.
  - LUT INIT == 32'hCAFE_F00D.
  - `OLD_DATA` == 32'h0000_0000 (the chain's prior contents).
- Same bench, second load 32'h1234_5678:
  - `OLD_DATA` == 32'hCAFE_F00D.
  - The LUT O6 output matches the new INIT for all 32 input addresses.
- `NUM_LUT=4`, `VERIFY=1`, image with LUT k INIT = 32'h0101_0101<<k:
  - `CE` high 256 cycles and `DONE` at cycle 257.
  - `VERIFY_ERR=0`, and each LUT holds its own INIT.
- `VERIFY=1` with the `CDO` bit forced to 0 during the verify pass, image 32'hFFFF_FFFF → `VERIFY_ERR=1` at `DONE`; the next accept clears it.
- `CFG_VALID` pulsed during LOAD with different data → ignored, the loaded image is unchanged, and `CFG_READY` stays 0 until after `DONE`.
- `RST_N` asserted at cycle 10 of a LOAD → `CE=0` immediately and all outputs return to reset values. A subsequent full load of 32'hA5A5_A5A5 yields a correct INIT.
